// File: rtl/coherence_ctrl.sv
// coherence_ctrl: two-core snooping coherence controller in front of a single
// word-wide RAM port. One request is served at a time; the other core is
// snooped before reads, and a dirty snooper's data is forwarded to the
// requester while memory is updated in the same access (cache-to-cache).
// Every transaction moves two words (RD1/RD2, WB1/WB2, C2C1/C2C2).
//
// Ports
//   CLK, RST                   clock, asynchronous active-high reset
//   dREN, dWEN [1:0]           per-core read / write request (bit n = core n)
//   daddr0/1, dstore0/1 [31:0] per-core word address and write data
//   cctrans, ccwrite [1:0]     core coherence status (see transaction states)
//   dwait [1:0]                per-core stall, low only in a word's completion cycle
//   dload [31:0]               read data broadcast to both cores
//   ccwait, ccinv [1:0]        snoop request / invalidate request per core
//   ccsnoopaddr0/1 [31:0]      address to snoop, valid while ccwait[n] is high
//   ramREN, ramWEN             RAM read / write strobes
//   ramaddr, ramstore [31:0]   RAM address / write data
//   ramload [31:0]             RAM read data
//   ram_ready                  RAM access completes this cycle
module coherence_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  dREN,
  input  logic [1:0]  dWEN,
  input  logic [31:0] daddr0,
  input  logic [31:0] daddr1,
  input  logic [31:0] dstore0,
  input  logic [31:0] dstore1,
  input  logic [1:0]  cctrans,
  input  logic [1:0]  ccwrite,
  output logic [1:0]  dwait,
  output logic [31:0] dload,
  output logic [1:0]  ccwait,
  output logic [1:0]  ccinv,
  output logic [31:0] ccsnoopaddr0,
  output logic [31:0] ccsnoopaddr1,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  typedef enum logic [3:0] {
    IDLE, ARB, SNOOP, RD1, RD2, C2C1, C2C2, WB1, WB2
  } state_t;

  state_t state_q, state_d;
  logic   req_q, req_d;
  logic   last_q, last_d;

  logic [31:0] addr  [2];
  logic [31:0] store [2];
  logic [31:0] snoop_addr [2];
  logic [1:0]  pending;
  logic        other;
  logic        hold;

  assign addr[0]  = daddr0;
  assign addr[1]  = daddr1;
  assign store[0] = dstore0;
  assign store[1] = dstore1;
  assign ccsnoopaddr0 = snoop_addr[0];
  assign ccsnoopaddr1 = snoop_addr[1];

  assign pending = dREN | dWEN;
  assign other   = ~req_q;
  // The granted core still wants the bus; losing this aborts the transaction.
  assign hold    = dREN[req_q] | dWEN[req_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    last_d        = last_q;
    dwait         = 2'b11;
    dload         = 32'h0;
    ccwait        = 2'b00;
    ccinv         = 2'b00;
    snoop_addr[0] = 32'h0;
    snoop_addr[1] = 32'h0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = 32'h0;
    ramstore      = 32'h0;

    case (state_q)
      IDLE: begin
        if (|pending) begin
          // Round-robin: on a tie the core that was not served last wins.
          req_d   = (pending == 2'b11) ? ~last_q : pending[1];
          state_d = ARB;
        end
      end

      ARB: begin
        if (dWEN[req_q])      state_d = WB1;
        else if (dREN[req_q]) state_d = SNOOP;
        else                  state_d = IDLE;
      end

      SNOOP: begin
        ccwait[other]     = 1'b1;
        ccinv[other]      = ccwrite[req_q];
        snoop_addr[other] = addr[req_q];
        if (!hold)                state_d = IDLE;
        else if (cctrans[other])  state_d = ccwrite[other] ? C2C1 : RD1;
      end

      RD1, RD2: begin
        ccwait[other]     = 1'b1;
        snoop_addr[other] = addr[req_q];
        ramREN            = 1'b1;
        ramaddr           = addr[req_q];
        dload             = ramload;
        if (!hold) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          dwait[req_q] = 1'b0;
          if (state_q == RD1) begin
            state_d = RD2;
          end else begin
            state_d = IDLE;
            last_d  = req_q;
          end
        end
      end

      // Snooper owns the dirty line: write it back and forward it in one access.
      C2C1, C2C2: begin
        ccwait[other]     = 1'b1;
        snoop_addr[other] = addr[req_q];
        ramWEN            = 1'b1;
        ramaddr           = addr[other];
        ramstore          = store[other];
        dload             = store[other];
        if (ram_ready) begin
          dwait = 2'b00;
          if (state_q == C2C1) begin
            state_d = C2C2;
          end else begin
            state_d = IDLE;
            last_d  = req_q;
          end
        end
      end

      WB1, WB2: begin
        ramWEN   = 1'b1;
        ramaddr  = addr[req_q];
        ramstore = store[req_q];
        if (!hold) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          dwait[req_q] = 1'b0;
          if (state_q == WB1) begin
            state_d = WB2;
          end else begin
            state_d = IDLE;
            last_d  = req_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
module tb_coherence_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  dREN = 2'b00;
  logic [1:0]  dWEN = 2'b00;
  logic [31:0] daddr0 = 32'h0;
  logic [31:0] daddr1 = 32'h0;
  logic [31:0] dstore0 = 32'h0;
  logic [31:0] dstore1 = 32'h0;
  logic [1:0]  cctrans = 2'b00;
  logic [1:0]  ccwrite = 2'b00;
  logic [1:0]  dwait;
  logic [31:0] dload;
  logic [1:0]  ccwait;
  logic [1:0]  ccinv;
  logic [31:0] ccsnoopaddr0;
  logic [31:0] ccsnoopaddr1;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = 32'h0;
  logic        ram_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  coherence_ctrl dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN),
    .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr0(ccsnoopaddr0), .ccsnoopaddr1(ccsnoopaddr1),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dwait", {30'h0, dwait}, 32'h3);
    chk("rst_ccwait", {30'h0, ccwait}, 32'h0);
    chk("rst_ccinv", {30'h0, ccinv}, 32'h0);
    chk("rst_ramstrb", {30'h0, ramREN, ramWEN}, 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_snoop", ccsnoopaddr0 | ccsnoopaddr1, 32'h0);
    RST = 1'b0;

    // Core0 read, core1 clean
    dREN = 2'b01; daddr0 = 32'h100;
    #1 chk("t1_idle_dwait", {30'h0, dwait}, 32'h3);
    tick();
    chk("t1_arb_ramren", {31'h0, ramREN}, 32'h0);
    chk("t1_arb_ccwait", {30'h0, ccwait}, 32'h0);
    tick();
    chk("t1_snp_ccwait", {30'h0, ccwait}, 32'h2);
    chk("t1_snp_addr1", ccsnoopaddr1, 32'h100);
    chk("t1_snp_ccinv", {30'h0, ccinv}, 32'h0);
    chk("t1_snp_ramren", {31'h0, ramREN}, 32'h0);
    chk("t1_snp_ramaddr", ramaddr, 32'h0);
    cctrans = 2'b10;
    tick();
    cctrans = 2'b00;
    #1;
    chk("t1_rd1_ramren", {31'h0, ramREN}, 32'h1);
    chk("t1_rd1_ramaddr", ramaddr, 32'h100);
    chk("t1_rd1_dwait", {30'h0, dwait}, 32'h3);
    chk("t1_rd1_ccwait", {30'h0, ccwait}, 32'h2);
    tick();
    ram_ready = 1'b1; ramload = 32'h1111_1111;
    #1;
    chk("t1_rd1_done", {30'h0, dwait}, 32'h2);
    chk("t1_rd1_dload", dload, 32'h1111_1111);
    tick();
    ram_ready = 1'b0; daddr0 = 32'h104;
    #1;
    chk("t1_rd2_dwait", {30'h0, dwait}, 32'h3);
    chk("t1_rd2_ramaddr", ramaddr, 32'h104);
    tick();
    ram_ready = 1'b1; ramload = 32'h2222_2222;
    #1;
    chk("t1_rd2_done", {30'h0, dwait}, 32'h2);
    chk("t1_rd2_dload", dload, 32'h2222_2222);
    tick();
    ram_ready = 1'b0; dREN = 2'b00;
    #1;
    chk("t1_end_ccwait", {30'h0, ccwait}, 32'h0);
    chk("t1_end_ramren", {31'h0, ramREN}, 32'h0);
    chk("t1_end_dwait", {30'h0, dwait}, 32'h3);
    chk("t1_end_snoop", ccsnoopaddr1, 32'h0);

    // Stray ram_ready in IDLE is ignored
    ram_ready = 1'b1;
    #1 chk("idle_rdy_dwait", {30'h0, dwait}, 32'h3);
    tick();
    chk("idle_rdy_strb", {30'h0, ramREN, ramWEN}, 32'h0);
    ram_ready = 1'b0;

    // Core1 read-for-write, core0 holds dirty copy
    dREN = 2'b10; ccwrite = 2'b10; daddr1 = 32'h200;
    tick();
    tick();
    chk("t2_snp_ccwait", {30'h0, ccwait}, 32'h1);
    chk("t2_snp_ccinv", {30'h0, ccinv}, 32'h1);
    chk("t2_snp_addr0", ccsnoopaddr0, 32'h200);
    cctrans = 2'b01; ccwrite = 2'b11; dstore0 = 32'hDEAD_BEEF; daddr0 = 32'h200;
    tick();
    cctrans = 2'b00;
    #1;
    chk("t2_c2c1_ramwen", {30'h0, ramREN, ramWEN}, 32'h1);
    chk("t2_c2c1_ramaddr", ramaddr, 32'h200);
    chk("t2_c2c1_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("t2_c2c1_dload", dload, 32'hDEAD_BEEF);
    chk("t2_c2c1_ccinv", {30'h0, ccinv}, 32'h0);
    chk("t2_c2c1_wait", {30'h0, dwait}, 32'h3);
    ram_ready = 1'b1;
    #1 chk("t2_c2c1_done", {30'h0, dwait}, 32'h0);
    tick();
    dstore0 = 32'hCAFE_F00D; daddr0 = 32'h204;
    #1;
    chk("t2_c2c2_dload", dload, 32'hCAFE_F00D);
    chk("t2_c2c2_ramaddr", ramaddr, 32'h204);
    chk("t2_c2c2_done", {30'h0, dwait}, 32'h0);
    tick();
    ram_ready = 1'b0; dREN = 2'b00; ccwrite = 2'b00;
    #1;
    chk("t2_end_ccwait", {30'h0, ccwait}, 32'h0);
    chk("t2_end_ramwen", {31'h0, ramWEN}, 32'h0);

    // Simultaneous writes after reset: core0 first, then core1
    RST = 1'b1;
    #1 RST = 1'b0;
    dWEN = 2'b11; daddr0 = 32'h300; dstore0 = 32'hA0; daddr1 = 32'h400; dstore1 = 32'hB0;
    tick();
    tick();
    chk("t3_wb1_ramwen", {30'h0, ramREN, ramWEN}, 32'h1);
    chk("t3_wb1_ramaddr", ramaddr, 32'h300);
    chk("t3_wb1_ramstore", ramstore, 32'hA0);
    chk("t3_wb1_ccwait", {30'h0, ccwait}, 32'h0);
    ram_ready = 1'b1;
    #1 chk("t3_wb1_done", {30'h0, dwait}, 32'h2);
    tick();
    chk("t3_wb2_done", {30'h0, dwait}, 32'h2);
    tick();
    ram_ready = 1'b0; dWEN = 2'b10;
    #1 chk("t3_idle_dwait", {30'h0, dwait}, 32'h3);
    tick();
    tick();
    chk("t3_c1_ramaddr", ramaddr, 32'h400);
    chk("t3_c1_ramstore", ramstore, 32'hB0);
    ram_ready = 1'b1;
    #1 chk("t3_c1_wb1_done", {30'h0, dwait}, 32'h1);
    tick();
    chk("t3_c1_wb2_done", {30'h0, dwait}, 32'h1);
    tick();
    ram_ready = 1'b0; dWEN = 2'b11;
    tick();
    tick();
    chk("t3_tie_after_c1", ramaddr, 32'h300);
    // Granted core drops its write mid-transaction
    dWEN = 2'b00;
    tick();
    chk("t3_abort_ramwen", {31'h0, ramWEN}, 32'h0);
    chk("t3_abort_dwait", {30'h0, dwait}, 32'h3);

    // Reset during RD2
    dREN = 2'b01; daddr0 = 32'h500;
    tick();
    tick();
    cctrans = 2'b10;
    tick();
    cctrans = 2'b00; ram_ready = 1'b1;
    #1 chk("t4_rd1_done", {30'h0, dwait}, 32'h2);
    tick();
    ram_ready = 1'b0;
    #1 chk("t4_rd2_ramren", {31'h0, ramREN}, 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("t4_rst_ramren", {31'h0, ramREN}, 32'h0);
    chk("t4_rst_dwait", {30'h0, dwait}, 32'h3);
    chk("t4_rst_ccwait", {30'h0, ccwait}, 32'h0);
    chk("t4_rst_ramaddr", ramaddr, 32'h0);
    dREN = 2'b00;
    RST = 1'b0;

    // Core0 drops read during SNOOP
    tick();
    dREN = 2'b01; daddr0 = 32'h600;
    tick();
    tick();
    chk("t5_snp_ccwait", {30'h0, ccwait}, 32'h2);
    dREN = 2'b00;
    tick();
    chk("t5_drop_ccwait", {30'h0, ccwait}, 32'h0);
    chk("t5_drop_strb", {30'h0, ramREN, ramWEN}, 32'h0);
    tick();
    chk("t5_idle_strb", {30'h0, ramREN, ramWEN}, 32'h0);

    // Random traffic with invariant checks
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK);
      #1;
      dREN      = 2'($urandom_range(0, 3));
      dWEN      = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      cctrans   = 2'($urandom_range(0, 3));
      ccwrite   = 2'($urandom_range(0, 3));
      ram_ready = ($urandom_range(0, 2) == 0);
      daddr0    = $urandom;
      daddr1    = $urandom;
      dstore0   = $urandom;
      dstore1   = $urandom;
      ramload   = $urandom;
      @(negedge CLK);
      chk("rnd_strobes", {31'h0, ramREN & ramWEN}, 32'h0);
      chk("rnd_both_dwait", {31'h0, (dwait == 2'b00) & ~ramWEN}, 32'h0);
      chk("rnd_ccwait_both", {31'h0, ccwait == 2'b11}, 32'h0);
      if (dwait != 2'b00)
        chk("rnd_grant_ccwait", {30'h0, ~dwait & ccwait}, 32'h0);
      chk("rnd_snoop0", (ccwait[0] == 1'b0) ? ccsnoopaddr0 : 32'h0, 32'h0);
      chk("rnd_snoop1", (ccwait[1] == 1'b0) ? ccsnoopaddr1 : 32'h0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
